borrow_lookahead_subtractor: RTL

- Multi-cycle unsigned subtractor: computes diff = a - b - bin over WIDTH bits, one 3-bit slice per clock.
- Each slice uses borrow lookahead: generate g = ~x & y; propagate p = ~(x ^ y); borrow_out = g | (p & borrow_in), expanded across the 3 bits of the slice.
- Complements the 3-bit carry-lookahead adder path. Sits in the datapath beside the adder and is driven by a start/done handshake from the controlling FSM.

---
 rtl/borrow_lookahead_subtractor.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/borrow_lookahead_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, one 3-bit slice per clock.
// Each slice resolves its three internal borrows in parallel (lookahead) from
// the slice generate/propagate terms and the running borrow carried between
// clock cycles. A start/done handshake frames each operation.

// Checker for handshake invariants; holds no state of its own.
module borrow_lookahead_subtractor_chk #(
  parameter int SLICES = 4,
  parameter int CW     = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          busy,
  input logic          done,
  input logic [CW-1:0] cnt
);

  // done and busy are never high together
  a_done_not_busy: assert property (@(posedge clk) disable iff (rst) !(done && busy));

  // done is a single-cycle pulse
  a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);

  // slice counter never runs past the last slice while busy
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) busy |-> (int'(cnt) < SLICES));

endmodule

module borrow_lookahead_subtractor #(
  parameter int WIDTH  = 12,
  parameter int SLICES = WIDTH / 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } state_t;

  // 3-bit borrow-lookahead slice. Returns {borrow_out, d[2:0]}.
  // g_i = ~x_i & y_i (bit borrows by itself), p_i = ~(x_i ^ y_i) (bit passes
  // an incoming borrow through). All three borrows are flattened sums of
  // products so no borrow ripples through another bit's logic.
  function automatic logic [3:0] slice_sub(
    input logic [2:0] x,
    input logic [2:0] y,
    input logic       c0
  );
    logic [2:0] g;
    logic [2:0] p;
    logic       c1;
    logic       c2;
    logic       c3;
    g  = ~x & y;
    p  = ~(x ^ y);
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    // d_i = x_i ^ y_i ^ c_i, and x_i ^ y_i is simply ~p_i
    return {c3, (~p) ^ {c2, c1, c0}};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  // Captured operands are shifted right by one slice each RUN cycle, so the
  // active slice is always in the low three bits.
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] b_s;
  logic             borrow_r;
  logic             borrow_s;
  logic [WIDTH-1:0] diff_r;
  logic [WIDTH-1:0] diff_s;
  logic             bout_r;
  logic             bout_s;
  logic             busy_r;
  logic             busy_s;
  logic             done_r;
  logic             done_s;
  logic [3:0]       slice_s;

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    a_s      = a_r;
    b_s      = b_r;
    borrow_s = borrow_r;
    diff_s   = diff_r;
    bout_s   = bout_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    slice_s  = slice_sub(a_r[2:0], b_r[2:0], borrow_r);

    case (state_r)
      st_idle, st_done: begin
        // DONE accepts start exactly like IDLE, allowing back-to-back operations
        if (start) begin
          a_s      = a;
          b_s      = b;
          borrow_s = bin;
          cnt_s    = {CW{1'b0}};
          diff_s   = {WIDTH{1'b0}};
          busy_s   = 1'b1;
          state_s  = st_run;
        end else begin
          busy_s   = 1'b0;
          state_s  = st_idle;
        end
      end

      st_run: begin
        // Only the slice selected by the counter is overwritten; others hold
        for (int k = 0; k < SLICES; k++) begin
          diff_s[3*k +: 3] = (cnt_r == CW'(k)) ? slice_s[2:0] : diff_r[3*k +: 3];
        end
        a_s      = a_r >> 3'd3;
        b_s      = b_r >> 3'd3;
        borrow_s = slice_s[3];
        if (cnt_r == LAST_SLICE) begin
          bout_s  = slice_s[3];
          busy_s  = 1'b0;
          done_s  = 1'b1;
          cnt_s   = {CW{1'b0}};
          state_s = st_done;
        end else begin
          cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          busy_s  = 1'b1;
          state_s = st_run;
        end
      end

      default: begin
        // Unreachable encoding: return to a safe idle state
        cnt_s    = {CW{1'b0}};
        busy_s   = 1'b0;
        state_s  = st_idle;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= st_idle;
      cnt_r    <= {CW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      bout_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      a_r      <= a_s;
      b_r      <= b_s;
      borrow_r <= borrow_s;
      diff_r   <= diff_s;
      bout_r   <= bout_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign diff = diff_r;
  assign bout = bout_r;
  assign busy = busy_r;
  assign done = done_r;

  borrow_lookahead_subtractor_chk #(
    .SLICES (SLICES),
    .CW     (CW)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .busy (busy_r),
    .done (done_r),
    .cnt  (cnt_r)
  );

endmodule
